alu_seq_datapath: RTL and testbench

- Generalised successor to the single-width A/B input register + ALU + ADD hold register datapath.
- Parametrised in width, adds an optional decimal (BCD) adjust cycle, and adds a start/busy/done handshake so the sequencer can issue one ALU operation at a time.
- Result is captured into an internal hold register that drives the address-low and system-bus outputs under per-field enables.

---
 rtl/alu_seq_datapath_if.sv | 55 +++++
 rtl/alu_seq_datapath.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_seq_datapath.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_datapath_if.sv
// ---------------------------------------------------------------------------
// alu_seq_datapath_if
// Groups the operand, control and result signals of the sequenced ALU
// datapath so the sequencer and the datapath connect with a single port.
//   master : sequencer side. Drives start/op/operand selects, operand buses
//            and output enables. Receives busy/done, hold, gated buses and
//            flags.
//   slave  : datapath side, which is the mirror of master.
// ---------------------------------------------------------------------------
interface alu_seq_datapath_if #(
   parameter int unsigned WIDTH = 8
);

   // Request and operation select
   logic             start_i;
   logic [2:0]       op_i;
   logic             a_sel_i;
   logic [1:0]       b_sel_i;
   logic             decimal_i;
   logic             carry_i;

   // Operand buses
   logic [WIDTH-1:0] sysbus_i;
   logic [WIDTH-1:0] dbus_i;
   logic [WIDTH-1:0] adl_i;

   // Output enables
   logic             adl_en_i;
   logic             sb_lo_en_i;
   logic             sb_msb_en_i;

   // Handshake and results
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] hold_o;
   logic [WIDTH-1:0] adl_o;
   logic [WIDTH-1:0] sb_o;
   logic             c_o;
   logic             v_o;
   logic             n_o;
   logic             z_o;

   modport master (
      output start_i, op_i, a_sel_i, b_sel_i, decimal_i, carry_i,
             sysbus_i, dbus_i, adl_i, adl_en_i, sb_lo_en_i, sb_msb_en_i,
      input  busy_o, done_o, hold_o, adl_o, sb_o, c_o, v_o, n_o, z_o
   );

   modport slave (
      input  start_i, op_i, a_sel_i, b_sel_i, decimal_i, carry_i,
             sysbus_i, dbus_i, adl_i, adl_en_i, sb_lo_en_i, sb_msb_en_i,
      output busy_o, done_o, hold_o, adl_o, sb_o, c_o, v_o, n_o, z_o
   );

endinterface

// File: rtl/alu_seq_datapath.sv
// ---------------------------------------------------------------------------
// alu_seq_datapath
// Sequenced A/B operand register, ALU and hold-register datapath. The
// datapath runs one operation per start request (IDLE -> LOAD -> EXEC ->
// [ADJ] -> DONE). The optional ADJ cycle performs a BCD correction on SUM.
// Ports:
//   phi2  : clock, rising-edge active.
//   reset : synchronous, active-high reset. Aborts any operation in flight.
//   bus   : alu_seq_datapath_if.slave, which carries the following signals.
//           start/op/carry/decimal are sampled in IDLE.
//           a_sel/b_sel and the operand buses are sampled in LOAD.
//           busy/done form the handshake.
//           hold, the c/v/n/z flags and the gated adl/sb views are the
//           results.
// ---------------------------------------------------------------------------
module alu_seq_datapath #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          DECIMAL_EN = 1'b1
) (
   input  logic              phi2,
   input  logic              reset,
   alu_seq_datapath_if.slave bus
);

   localparam int unsigned WP1 = WIDTH + 1;
   localparam int unsigned NIB = WIDTH / 4;
   // Decimal adjust only exists when the width splits into whole nibbles.
   localparam bit DEC_OK = DECIMAL_EN && ((WIDTH % 4) == 0);

   localparam logic [2:0] OP_SUM = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_EOR = 3'b011;
   localparam logic [2:0] OP_SR  = 3'b100;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      EXEC = 3'd2,
      ADJ  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [2:0]       op_q;
   logic             dec_q;
   logic             cin_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] hold_q;
   logic [NIB-1:0]   nc_q;
   logic             c_q;
   logic             v_q;
   logic             n_q;
   logic             z_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] b_mux;
   logic [WP1-1:0]   sum_full;
   logic [NIB-1:0]   nib_carry;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic [WIDTH-1:0] adj_res;
   logic             adj_c;

   // Next-state logic
   always_comb begin : fsm_next
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start_i) state_d = LOAD;
         LOAD:    state_d = EXEC;
         EXEC:    state_d = ((op_q == OP_SUM) && dec_q) ? ADJ : DONE;
         ADJ:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // B operand source select
   always_comb begin : b_select
      b_mux = '0;
      case (bus.b_sel_i)
         2'b00:   b_mux = bus.dbus_i;
         2'b01:   b_mux = ~bus.dbus_i;
         2'b10:   b_mux = bus.adl_i;
         default: b_mux = '0;
      endcase
   end

   // Binary adder, plus the per-nibble carry-outs that the BCD adjust needs
   always_comb begin : adder
      logic [4:0] nsum;
      logic       ncarry;
      sum_full  = WP1'(a_q) + WP1'(b_q) + WP1'(cin_q);
      nib_carry = '0;
      nsum      = '0;
      ncarry    = cin_q;
      for (int unsigned k = 0; k < NIB; k++) begin
         nsum         = 5'(a_q[4*k +: 4]) + 5'(b_q[4*k +: 4]) + 5'(ncarry);
         nib_carry[k] = nsum[4];
         ncarry       = nsum[4];
      end
   end

   // ALU function. The AND/OR/EOR operations leave C/V unchanged. SR leaves V unchanged.
   always_comb begin : alu
      alu_res = a_q & b_q;
      alu_c   = c_q;
      alu_v   = v_q;
      case (op_q)
         OP_SUM: begin
            alu_res = sum_full[WIDTH-1:0];
            alu_c   = sum_full[WIDTH];
            alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (sum_full[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_EOR:  alu_res = a_q ^ b_q;
         OP_SR: begin
            alu_res = {cin_q, a_q[WIDTH-1:1]};
            alu_c   = a_q[0];
         end
         default: alu_res = a_q & b_q;
      endcase
   end

   // BCD adjust on the binary sum held in hold_q. The binary carry has
   // already rippled into each nibble. Only the carry produced by the +6
   // correction ripples further. A nibble's decimal carry is its binary
   // carry-out or its correction carry.
   always_comb begin : bcd_adjust
      logic [4:0] t;
      logic [4:0] u;
      logic       r;
      logic       dc;
      adj_res = hold_q;
      t       = '0;
      u       = '0;
      r       = 1'b0;
      dc      = 1'b0;
      for (int unsigned k = 0; k < NIB; k++) begin
         t = 5'(hold_q[4*k +: 4]) + 5'(r);
         u = ((t > 5'd9) || nc_q[k]) ? (t + 5'd6) : t;
         adj_res[4*k +: 4] = u[3:0];
         r  = u[4];
         dc = nc_q[k] | u[4];
      end
      adj_c = dc;
   end

   // State register, operand/result registers and handshake outputs
   always_ff @(posedge phi2) begin : regs
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         dec_q   <= 1'b0;
         cin_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         hold_q  <= '0;
         nc_q    <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
         case (state_q)
            IDLE: begin
               if (bus.start_i) begin
                  op_q  <= bus.op_i;
                  dec_q <= bus.decimal_i & DEC_OK;
                  cin_q <= bus.carry_i;
               end
            end
            LOAD: begin
               a_q <= bus.a_sel_i ? '0 : bus.sysbus_i;
               b_q <= b_mux;
            end
            EXEC: begin
               hold_q <= alu_res;
               nc_q   <= nib_carry;
               c_q    <= alu_c;
               v_q    <= alu_v;
               n_q    <= alu_res[WIDTH-1];
               z_q    <= (alu_res == '0);
            end
            ADJ: begin
               hold_q <= adj_res;
               c_q    <= adj_c;
               n_q    <= adj_res[WIDTH-1];
               z_q    <= (adj_res == '0);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_o = busy_q;
   assign bus.done_o = done_q;
   assign bus.hold_o = hold_q;
   assign bus.c_o    = c_q;
   assign bus.v_o    = v_q;
   assign bus.n_o    = n_q;
   assign bus.z_o    = z_q;

   // Gated views of the hold register. Disabled bits read as zero.
   assign bus.adl_o = bus.adl_en_i ? hold_q : '0;
   assign bus.sb_o  = {bus.sb_msb_en_i & hold_q[WIDTH-1],
                       hold_q[WIDTH-2:0] & {(WIDTH-1){bus.sb_lo_en_i}}};

endmodule

// File: tb/tb_alu_seq_datapath.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_datapath
// Drives an 8-bit and a 16-bit datapath. Each issued operation pushes its
// expected result from an arithmetic reference model into a per-DUT queue.
// A monitor pops and compares whenever done_o is seen.
// ---------------------------------------------------------------------------
module tb_alu_seq_datapath;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_seq_datapath_if #(.WIDTH(8))  i8 ();
   alu_seq_datapath_if #(.WIDTH(16)) i16 ();

   alu_seq_datapath #(.WIDTH(8),  .DECIMAL_EN(1'b1)) dut8  (.phi2(clk), .reset(rst), .bus(i8));
   alu_seq_datapath #(.WIDTH(16), .DECIMAL_EN(1'b1)) dut16 (.phi2(clk), .reset(rst), .bus(i16));

   typedef struct {
      logic [15:0] hold;
      bit          c, v, n, z;
      int          start_cyc;
      int          lat;
   } exp_t;

   exp_t q8[$];
   exp_t q16[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mc8 = 0, mv8 = 0, mc16 = 0, mv16 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint bcd2int(input longint x, input int w);
      longint v = 0, p = 1;
      for (int k = 0; k < w / 4; k++) begin
         v += ((x >> (4 * k)) & 15) * p;
         p *= 10;
      end
      return v;
   endfunction

   function automatic longint int2bcd(input longint x, input int w);
      longint v = 0, t = x;
      for (int k = 0; k < w / 4; k++) begin
         v |= (t % 10) << (4 * k);
         t /= 10;
      end
      return v;
   endfunction

   function automatic longint rand_bcd(input int w);
      longint v = 0;
      for (int k = 0; k < w / 4; k++) v |= longint'($urandom_range(0, 9)) << (4 * k);
      return v;
   endfunction

   // Reference model. It uses signed range for V and decimal integer arithmetic for BCD.
   function automatic exp_t model(input int w, input int op, input int a_sel, input int b_sel,
                                  input int dec, input int cin, input longint sys,
                                  input longint db, input longint adl, input bit cp, input bit vp);
      exp_t   e;
      longint mask, half, a, b, res, s, sa, sb, lim;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      a = (a_sel != 0) ? 0 : (sys & mask);
      case (b_sel)
         0:       b = db & mask;
         1:       b = ~db & mask;
         2:       b = adl & mask;
         default: b = 0;
      endcase
      e.c = cp; e.v = vp; e.start_cyc = 0; e.lat = 0;
      case (op)
         0: begin
            sa = (a >= half) ? a - 2 * half : a;
            sb = (b >= half) ? b - 2 * half : b;
            s  = sa + sb + cin;
            e.v = (s >= half) || (s < -half);
            if (dec != 0) begin
               lim = 1;
               for (int k = 0; k < w / 4; k++) lim *= 10;
               s   = bcd2int(a, w) + bcd2int(b, w) + cin;
               e.c = (s >= lim);
               res = int2bcd(s % lim, w);
            end else begin
               s   = a + b + cin;
               e.c = (s > mask);
               res = s & mask;
            end
         end
         2:       res = a | b;
         3:       res = a ^ b;
         4: begin
            res = (longint'(cin) << (w - 1)) | (a >> 1);
            e.c = (a & 1) != 0;
         end
         default: res = a & b;
      endcase
      e.hold = 16'(res);
      e.n    = ((res >> (w - 1)) & 1) != 0;
      e.z    = (res == 0);
      return e;
   endfunction

   task automatic drive_ctrl(input int which, input bit st, input int op, input int dec, input int cin);
      if (which == 0) begin
         i8.start_i = st; i8.op_i = 3'(op); i8.decimal_i = 1'(dec); i8.carry_i = 1'(cin);
      end else begin
         i16.start_i = st; i16.op_i = 3'(op); i16.decimal_i = 1'(dec); i16.carry_i = 1'(cin);
      end
   endtask

   task automatic drive_ops(input int which, input int a_sel, input int b_sel,
                            input longint sys, input longint db, input longint adl);
      if (which == 0) begin
         i8.a_sel_i = 1'(a_sel); i8.b_sel_i = 2'(b_sel);
         i8.sysbus_i = 8'(sys); i8.dbus_i = 8'(db); i8.adl_i = 8'(adl);
      end else begin
         i16.a_sel_i = 1'(a_sel); i16.b_sel_i = 2'(b_sel);
         i16.sysbus_i = 16'(sys); i16.dbus_i = 16'(db); i16.adl_i = 16'(adl);
      end
   endtask

   task automatic drive_en(input int which, input int en);
      if (which == 0) begin
         i8.adl_en_i = en[0]; i8.sb_lo_en_i = en[1]; i8.sb_msb_en_i = en[2];
      end else begin
         i16.adl_en_i = en[0]; i16.sb_lo_en_i = en[1]; i16.sb_msb_en_i = en[2];
      end
   endtask

   // One transaction. Control is valid only in the start cycle, and operands only in the LOAD cycle.
   task automatic do_op(input int which, input int op, input int a_sel, input int b_sel,
                        input int dec, input int cin, input longint sys, input longint db,
                        input longint adl, input bit pulse);
      exp_t e;
      bit   got = 0;
      int   w = (which == 0) ? 8 : 16;
      @(posedge clk); #1;
      drive_ctrl(which, 1'b1, op, dec, cin);
      drive_ops(which, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                longint'($urandom), longint'($urandom), longint'($urandom));
      drive_en(which, int'($urandom_range(0, 7)));
      if (which == 0) begin
         e = model(w, op, a_sel, b_sel, dec, cin, sys, db, adl, mc8, mv8);
         mc8 = e.c; mv8 = e.v;
      end else begin
         e = model(w, op, a_sel, b_sel, dec, cin, sys, db, adl, mc16, mv16);
         mc16 = e.c; mv16 = e.v;
      end
      e.start_cyc = cyc;
      e.lat = (op == 0 && dec != 0) ? 4 : 3;
      if (which == 0) q8.push_back(e); else q16.push_back(e);
      @(posedge clk); #1;
      drive_ctrl(which, 1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)));
      drive_ops(which, a_sel, b_sel, sys, db, adl);
      if (pulse) begin
         @(posedge clk); #1;
         if (which == 0) i8.start_i = 1'b1; else i16.start_i = 1'b1;
         @(posedge clk); #1;
         if (which == 0) i8.start_i = 1'b0; else i16.start_i = 1'b0;
      end
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge clk);
         if ((which == 0) ? i8.done_o : i16.done_o) got = 1;
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL done_timeout: no done_o from dut%0d within 12 cycles", w);
      end
   endtask

   task automatic rand_op(input int which);
      int w = (which == 0) ? 8 : 16;
      int op, dec, bs;
      if ($urandom_range(0, 3) == 0) begin
         bs = int'($urandom_range(0, 1)) * 2;
         do_op(which, 0, int'($urandom_range(0, 1)), bs, 1, int'($urandom_range(0, 1)),
               rand_bcd(w), rand_bcd(w), rand_bcd(w), $urandom_range(0, 3) == 0);
      end else begin
         op  = int'($urandom_range(0, 7));
         dec = (op == 0) ? 0 : int'($urandom_range(0, 1));
         do_op(which, op, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), dec,
               int'($urandom_range(0, 1)), longint'($urandom), longint'($urandom),
               longint'($urandom), $urandom_range(0, 3) == 0);
      end
   endtask

   // Scoreboard monitor for the 8-bit DUT
   always @(negedge clk) begin
      exp_t e;
      if (!rst && i8.done_o) begin
         if (q8.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL done8_unexpected: done_o with no outstanding operation");
         end else begin
            e = q8.pop_front();
            chk("hold8", 32'(i8.hold_o), 32'(e.hold[7:0]));
            chk("flags8_cvnz", 32'({i8.c_o, i8.v_o, i8.n_o, i8.z_o}), 32'({e.c, e.v, e.n, e.z}));
            chk("latency8", 32'(cyc - e.start_cyc), 32'(e.lat));
            chk("busy8_at_done", 32'(i8.busy_o), 32'd1);
            chk("adl8_gate", 32'(i8.adl_o), i8.adl_en_i ? 32'(e.hold[7:0]) : 32'd0);
            chk("sb8_gate", 32'(i8.sb_o),
                32'((i8.sb_lo_en_i ? e.hold[7:0] & 8'h7F : 8'h00) |
                    (i8.sb_msb_en_i ? e.hold[7:0] & 8'h80 : 8'h00)));
         end
      end
   end

   // Scoreboard monitor for the 16-bit DUT
   always @(negedge clk) begin
      exp_t e;
      if (!rst && i16.done_o) begin
         if (q16.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL done16_unexpected: done_o with no outstanding operation");
         end else begin
            e = q16.pop_front();
            chk("hold16", 32'(i16.hold_o), 32'(e.hold));
            chk("flags16_cvnz", 32'({i16.c_o, i16.v_o, i16.n_o, i16.z_o}), 32'({e.c, e.v, e.n, e.z}));
            chk("latency16", 32'(cyc - e.start_cyc), 32'(e.lat));
            chk("adl16_gate", 32'(i16.adl_o), i16.adl_en_i ? 32'(e.hold) : 32'd0);
            chk("sb16_gate", 32'(i16.sb_o),
                32'((i16.sb_lo_en_i ? e.hold & 16'h7FFF : 16'h0000) |
                    (i16.sb_msb_en_i ? e.hold & 16'h8000 : 16'h0000)));
         end
      end
   end

   initial begin
      bit seen_done;
      drive_ctrl(0, 1'b0, 0, 0, 0); drive_ops(0, 0, 0, 0, 0, 0); drive_en(0, 0);
      drive_ctrl(1, 1'b0, 0, 0, 0); drive_ops(1, 0, 0, 0, 0, 0); drive_en(1, 0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset8_hold", 32'(i8.hold_o), 32'd0);
      chk("reset8_flags", 32'({i8.c_o, i8.v_o, i8.n_o, i8.z_o}), 32'd0);
      chk("reset8_busy_done", 32'({i8.busy_o, i8.done_o}), 32'd0);
      chk("reset16_all", 32'({i16.hold_o, i16.c_o, i16.v_o, i16.n_o, i16.z_o, i16.busy_o, i16.done_o}), 32'd0);

      // Directed 8-bit cases
      do_op(0, 0, 0, 0, 0, 0, 'h50, 'hD0, 0, 0);
      chk("sum_50_d0", 32'({i8.hold_o, i8.c_o, i8.v_o}), 32'({8'h20, 1'b1, 1'b0}));
      do_op(0, 0, 0, 0, 0, 0, 'h50, 'h50, 0, 0);
      chk("sum_50_50", 32'({i8.hold_o, i8.c_o, i8.v_o, i8.n_o}), 32'({8'hA0, 1'b0, 1'b1, 1'b1}));
      do_op(0, 0, 0, 1, 0, 1, 'h01, 'h01, 0, 0);
      chk("sub_01_01", 32'({i8.hold_o, i8.c_o, i8.z_o}), 32'({8'h00, 1'b1, 1'b1}));
      do_op(0, 0, 0, 0, 1, 0, 'h45, 'h38, 0, 0);
      chk("dec_45_38", 32'({i8.hold_o, i8.c_o}), 32'({8'h83, 1'b0}));
      do_op(0, 0, 0, 0, 1, 0, 'h99, 'h01, 0, 0);
      chk("dec_99_01", 32'({i8.hold_o, i8.c_o, i8.z_o}), 32'({8'h00, 1'b1, 1'b1}));
      do_op(0, 1, 0, 0, 0, 0, 'h1F, 'h28, 0, 0);
      do_op(0, 2, 0, 0, 0, 0, 'h1F, 'h28, 0, 0);
      do_op(0, 3, 0, 0, 0, 0, 'h1F, 'h28, 0, 0);
      chk("eor_1f_28", 32'(i8.hold_o), 32'h37);
      do_op(0, 4, 0, 0, 0, 1, 'h03, 'h55, 0, 0);
      chk("sr_03_cin1", 32'({i8.hold_o, i8.c_o, i8.n_o}), 32'({8'h81, 1'b1, 1'b1}));
      do_op(0, 0, 0, 2, 0, 0, 'h11, 'h00, 'h22, 1);   // start pulsed while busy

      // Output gating with hold = A5
      do_op(0, 2, 0, 3, 0, 0, 'hA5, 'h00, 'h00, 0);
      @(posedge clk); #1 drive_en(0, 1);
      @(negedge clk);
      chk("gate_adl_only", 32'({i8.adl_o, i8.sb_o}), 32'({8'hA5, 8'h00}));
      @(posedge clk); #1 drive_en(0, 2);
      @(negedge clk);
      chk("gate_sb_lo_only", 32'({i8.adl_o, i8.sb_o}), 32'({8'h00, 8'h25}));
      @(posedge clk); #1 drive_en(0, 4);
      @(negedge clk);
      chk("gate_sb_msb_only", 32'({i8.adl_o, i8.sb_o}), 32'({8'h00, 8'h80}));

      // Reset in EXEC aborts without a done pulse
      do_op(0, 2, 0, 0, 0, 0, 'hFF, 'hFF, 0, 0);
      @(posedge clk); #1;
      drive_ctrl(0, 1'b1, 0, 0, 1);
      @(posedge clk); #1;
      drive_ctrl(0, 1'b0, 0, 0, 0);
      drive_ops(0, 0, 0, 'h12, 'h34, 0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_exec_hold", 32'(i8.hold_o), 32'd0);
      chk("rst_exec_flags_busy_done",
          32'({i8.c_o, i8.v_o, i8.n_o, i8.z_o, i8.busy_o, i8.done_o}), 32'd0);
      mc8 = 0; mv8 = 0; mc16 = 0; mv16 = 0;
      seen_done = 0;
      repeat (5) begin
         @(negedge clk);
         if (i8.done_o) seen_done = 1;
      end
      chk("rst_exec_no_done", 32'(seen_done), 32'd0);

      // Directed 16-bit cases
      do_op(1, 0, 0, 0, 0, 0, 'h7FFF, 'h0001, 0, 0);
      chk("sum16_7fff_1", 32'({i16.hold_o, i16.v_o, i16.n_o}), 32'({16'h8000, 1'b1, 1'b1}));
      do_op(1, 0, 0, 2, 1, 0, 'h9999, 0, 'h0001, 0);
      chk("dec16_9999_1", 32'({i16.hold_o, i16.c_o, i16.z_o}), 32'({16'h0000, 1'b1, 1'b1}));

      // Randomised traffic
      for (int i = 0; i < 150; i++) rand_op(0);
      for (int i = 0; i < 40; i++) rand_op(1);

      repeat (3) @(negedge clk);
      chk("q8_drained", 32'(q8.size()), 32'd0);
      chk("q16_drained", 32'(q16.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
